// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer: one line read, beat assembly,
// per-set round-robin victim selection and a single array write.
module icache_refill_ctrl #(
    parameter int PLEN       = 32,
    parameter int LINE_WIDTH = 256,
    parameter int SET_ASSOC  = 4,
    parameter int NUM_SETS   = 64,
    parameter int MEM_DW     = 64,
    localparam int BEATS     = LINE_WIDTH / MEM_DW,
    localparam int OFFSET_W  = $clog2(LINE_WIDTH / 8),
    localparam int INDEX_W   = $clog2(NUM_SETS),
    localparam int TAG_W     = PLEN - INDEX_W - OFFSET_W,
    localparam int WAY_W     = $clog2(SET_ASSOC)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [PLEN-1:0]       miss_paddr_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PLEN-1:0]       mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [MEM_DW-1:0]     mem_rsp_data_i,
    output logic                  wr_en_o,
    output logic [SET_ASSOC-1:0]  wr_way_o,
    output logic [INDEX_W-1:0]    wr_index_o,
    output logic [TAG_W-1:0]      wr_tag_o,
    output logic [LINE_WIDTH-1:0] wr_data_o,
    output logic                  refill_done_o,
    output logic                  busy_o
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, WRITE} state_e;

    state_e                state_q, state_d;
    logic [TAG_W-1:0]      tag_q;
    logic [INDEX_W-1:0]    index_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic [WAY_W-1:0]      ptr_q [NUM_SETS];
    logic                  last_beat;
    logic                  accept;
    logic                  unused_offset;

    assign accept        = (state_q == IDLE) && miss_valid_i && !flush_i;
    assign last_beat     = mem_rsp_valid_i && (cnt_q == LAST);
    assign unused_offset = ^miss_paddr_i[OFFSET_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tag_q   <= '0;
            index_q <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
            for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q   <= miss_paddr_i[PLEN-1 -: TAG_W];
                index_q <= miss_paddr_i[OFFSET_W +: INDEX_W];
                cnt_q   <= '0;
            end
            // Aborted refills keep counting so the bus is fully drained
            if ((state_q == RESP || state_q == DRAIN) && mem_rsp_valid_i) begin
                cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
                if (state_q == RESP) begin
                    for (int b = 0; b < BEATS; b++)
                        if (cnt_q == CNT_W'(b))
                            line_q[b*MEM_DW +: MEM_DW] <= mem_rsp_data_i;
                end
            end
            if (state_q == WRITE) ptr_q[index_q] <= ptr_q[index_q] + WAY_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = REQ;
            REQ: begin
                if (flush_i)              state_d = mem_req_ready_i ? DRAIN : IDLE;
                else if (mem_req_ready_i) state_d = RESP;
            end
            RESP: begin
                if (flush_i)        state_d = last_beat ? IDLE : DRAIN;
                else if (last_beat) state_d = WRITE;
            end
            DRAIN: if (last_beat) state_d = IDLE;
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miss_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        wr_en_o         = 1'b0;
        refill_done_o   = 1'b0;
        wr_way_o        = '0;
        wr_index_o      = '0;
        wr_tag_o        = '0;
        wr_data_o       = '0;
        busy_o          = (state_q != IDLE);
        unique case (state_q)
            IDLE: miss_ready_o = 1'b1;
            REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {tag_q, index_q, {OFFSET_W{1'b0}}};
            end
            WRITE: begin
                wr_en_o       = 1'b1;
                refill_done_o = 1'b1;
                wr_way_o      = SET_ASSOC'(1) << ptr_q[index_q];
                wr_index_o    = index_q;
                wr_tag_o      = tag_q;
                wr_data_o     = line_q;
            end
            default: ;
        endcase
    end

    a_rsp_protocol: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_rsp_valid_i &&
          (state_q == IDLE || state_q == REQ || state_q == WRITE)));

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl with a transaction-level
// expectation model compared against the outputs on every cycle.
module tb_icache_refill_ctrl;

    localparam int LW    = 256;
    localparam int DW    = 64;
    localparam int BEATS = LW / DW;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, miss_valid_i, miss_ready_o;
    logic [31:0]   miss_paddr_i, mem_req_addr_o;
    logic          mem_req_valid_o, mem_req_ready_i;
    logic          mem_rsp_valid_i;
    logic [DW-1:0] mem_rsp_data_i;
    logic          wr_en_o, refill_done_o, busy_o;
    logic [3:0]    wr_way_o;
    logic [5:0]    wr_index_o;
    logic [20:0]   wr_tag_o;
    logic [LW-1:0] wr_data_o;

    icache_refill_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
        .miss_paddr_i(miss_paddr_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .wr_en_o(wr_en_o), .wr_way_o(wr_way_o), .wr_index_o(wr_index_o),
        .wr_tag_o(wr_tag_o), .wr_data_o(wr_data_o),
        .refill_done_o(refill_done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 0;

    logic          e_ready, e_req, e_wr, e_busy;
    logic [31:0]   e_addr;
    logic [3:0]    e_way;
    logic [5:0]    e_idx;
    logic [20:0]   e_tag;
    logic [LW-1:0] e_data;

    int ptr_m [64];

    logic [31:0]   obs_addr;
    logic [3:0]    obs_way;
    logic [5:0]    obs_idx;
    logic [LW-1:0] obs_data;

    task automatic chk(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("miss_ready", miss_ready_o, e_ready);
        chk("req_valid", mem_req_valid_o, e_req);
        chk("req_addr", mem_req_addr_o, e_addr);
        chk("wr_en", wr_en_o, e_wr);
        chk("done", refill_done_o, e_wr);
        chk("wr_way", wr_way_o, e_way);
        chk("wr_index", wr_index_o, e_idx);
        chk("wr_tag", wr_tag_o, e_tag);
        chk("wr_data", wr_data_o, e_data);
        chk("busy", busy_o, e_busy);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_ready = 1; e_req = 0; e_addr = '0; e_wr = 0; e_way = '0;
        e_idx = '0; e_tag = '0; e_data = '0; e_busy = 0;
    endtask

    task automatic set_busy();
        set_idle();
        e_ready = 0;
        e_busy  = 1;
    endtask

    function automatic logic [31:0] mk_pa(input int idx);
        logic [31:0] pa;
        pa       = $urandom;
        pa[10:5] = 6'(idx);
        return pa;
    endfunction

    // kind: 0 none, 1 flush in REQ before ready, 2 flush on handshake,
    // 3 flush in RESP once fpt beats have arrived (fbeat: beat in that cycle)
    task automatic run_miss(input logic [31:0] pa, input int wait_n,
                            input int kind, input int fpt, input bit fbeat,
                            input bit fixed);
        int          idx, k;
        bit          ab, v;
        logic [LW-1:0] line;
        idx  = int'(pa[10:5]);
        line = '0;
        miss_valid_i = 1; miss_paddr_i = pa; flush_i = 0;
        step();
        miss_valid_i = 1'($urandom); miss_paddr_i = $urandom;
        set_busy(); e_req = 1; e_addr = {pa[31:5], 5'b0};
        obs_addr = mem_req_addr_o;
        for (int w = 0; w <= wait_n; w++) begin
            if (kind == 1 && w == fpt) begin
                mem_req_ready_i = 0; flush_i = 1;
                step();
                flush_i = 0; miss_valid_i = 0;
                set_idle();
                return;
            end
            mem_req_ready_i = (w == wait_n);
            flush_i = (kind == 2 && w == wait_n);
            step();
        end
        mem_req_ready_i = 0; flush_i = 0;
        set_busy();
        ab = (kind == 2);
        k  = 0;
        while (k < BEATS) begin
            v = fixed ? 1'b1 : ($urandom % 3 != 0);
            if (kind == 3 && !ab && k == fpt) begin
                flush_i = 1; v = fbeat; ab = 1;
            end
            mem_rsp_valid_i = v;
            mem_rsp_data_i  = fixed ? {8{8'(8'h11 * (k + 1))}}
                                    : {$urandom, $urandom};
            if (v && !ab) line[k*DW +: DW] = mem_rsp_data_i;
            miss_valid_i = 1'($urandom);
            step();
            flush_i = 0;
            if (v) k++;
        end
        mem_rsp_valid_i = 0;
        if (ab) begin
            set_idle();
            miss_valid_i = 0;
            return;
        end
        set_busy();
        e_wr = 1; e_way = 4'(1 << ptr_m[idx]); e_idx = pa[10:5];
        e_tag = pa[31:11]; e_data = line;
        obs_way = wr_way_o; obs_idx = wr_index_o; obs_data = wr_data_o;
        flush_i = 1'($urandom);
        step();
        flush_i = 0; miss_valid_i = 0;
        ptr_m[idx] = (ptr_m[idx] + 1) % 4;
        set_idle();
    endtask

    initial begin
        int r, w;
        rst_i = 1; flush_i = 0; miss_valid_i = 0; miss_paddr_i = '0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = '0;
        foreach (ptr_m[i]) ptr_m[i] = 0;
        set_idle();
        step(); step();
        chk_en = 1;
        rst_i  = 0;
        chk("reset_ready", miss_ready_o, 1);
        chk("reset_busy", busy_o, 0);

        run_miss(32'h8000_1234, 0, 0, 0, 0, 1);
        chk("t1_addr", obs_addr, 32'h8000_1220);
        chk("t1_index", obs_idx, 6'h11);
        chk("t1_way", obs_way, 4'b0001);
        chk("t1_data", obs_data, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        run_miss(mk_pa(5), 0, 0, 0, 0, 0); chk("t2_w0", obs_way, 4'b0001);
        run_miss(mk_pa(5), 1, 0, 0, 0, 0); chk("t2_w1", obs_way, 4'b0010);
        run_miss(mk_pa(6), 0, 0, 0, 0, 0); chk("t2_i6", obs_way, 4'b0001);
        run_miss(mk_pa(5), 0, 0, 0, 0, 0); chk("t2_w2", obs_way, 4'b0100);
        run_miss(mk_pa(5), 2, 0, 0, 0, 0); chk("t2_w3", obs_way, 4'b1000);
        run_miss(mk_pa(5), 0, 0, 0, 0, 0); chk("t2_wrap", obs_way, 4'b0001);

        run_miss(mk_pa(7), 3, 0, 0, 0, 0);

        run_miss(mk_pa(5), 0, 3, 2, 0, 0);
        run_miss(mk_pa(5), 0, 0, 0, 0, 0); chk("t4_ptr", obs_way, 4'b0010);

        run_miss(mk_pa(5), 2, 1, 1, 0, 0);
        miss_valid_i = 1; flush_i = 1; miss_paddr_i = mk_pa(5);
        step(); step(); step();
        miss_valid_i = 0; flush_i = 0;
        run_miss(mk_pa(5), 0, 0, 0, 0, 0); chk("t5_ptr", obs_way, 4'b0100);

        miss_valid_i = 1; miss_paddr_i = mk_pa(9);
        step();
        miss_valid_i = 0;
        set_busy(); e_req = 1; e_addr = {miss_paddr_i[31:5], 5'b0};
        mem_req_ready_i = 1;
        step();
        mem_req_ready_i = 0;
        set_busy();
        for (int b = 0; b < 2; b++) begin
            mem_rsp_valid_i = 1; mem_rsp_data_i = {$urandom, $urandom};
            step();
        end
        mem_rsp_valid_i = 0; rst_i = 1;
        step();
        rst_i = 0;
        set_idle();
        foreach (ptr_m[i]) ptr_m[i] = 0;
        run_miss(mk_pa(5), 0, 0, 0, 0, 0); chk("t6_ptr", obs_way, 4'b0001);

        run_miss(mk_pa(3), 1, 3, BEATS - 1, 1, 0);
        run_miss(mk_pa(3), 0, 3, BEATS - 1, 0, 0);
        run_miss(mk_pa(3), 2, 2, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom % 8;
            w = $urandom % 4;
            if (r == 5)      run_miss(mk_pa($urandom % 4), w + 1, 1,
                                      $urandom % (w + 1), 0, 0);
            else if (r == 6) run_miss(mk_pa($urandom % 4), w, 2, 0, 0, 0);
            else if (r == 7) run_miss(mk_pa($urandom % 4), w, 3,
                                      $urandom % BEATS, 1'($urandom), 0);
            else             run_miss(mk_pa($urandom % 4), w, 0, 0, 0, 0);
            if ($urandom % 4 == 0) step();
        end
        step();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
